// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and load status of imem_loader.
// The host or bench drives through master; the loader connects through slave.
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        cpu_nclear;
  logic        done;
  logic        error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_nclear, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_nclear, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed, big-endian word image from a byte host into instruction memory.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the last word.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input logic         clk,
  input logic         nClear,
  imem_loader_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state, next_state;
  logic        ready;
  logic        accept;
  logic        last;
  logic        cpu_nclear_q;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [15:0] len;
  logic [15:0] len_word;
  logic [15:0] index;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  assign accept   = bus.byte_valid && ready;
  assign len_word = {len_hi, bus.byte_data};
  assign last     = (index == len - 16'd1);

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) next_state = LEN_HI;
      end
      LEN_HI: begin
        ready = 1'b1;
        if (bus.byte_valid) next_state = LEN_LO;
      end
      LEN_LO: begin
        ready = 1'b1;
        if (bus.byte_valid) begin
          if (len_word == 16'd0 || {1'b0, len_word} > MAX_W) next_state = ERR;
          else                                               next_state = DATA_HI;
        end
      end
      DATA_HI: begin
        ready = 1'b1;
        if (bus.byte_valid) next_state = DATA_LO;
      end
      DATA_LO: begin
        ready = 1'b1;
        if (bus.byte_valid) next_state = WRITE;
      end
      WRITE: begin
        if (last) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = DATA_HI;
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        ready = 1'b1;
        if (bus.byte_valid) next_state = (bus.byte_data == checksum) ? DONE : ERR;
`else
        next_state = ERR;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // The write address and data are latched on the low-byte accept so they are valid
  // throughout WRITE and simply hold afterwards.
  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      cpu_nclear_q <= 1'b0;
      len_hi       <= 8'h00;
      data_hi      <= 8'h00;
      len          <= 16'h0000;
      index        <= 16'h0000;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
    end else begin
      cpu_nclear_q <= (next_state == IDLE) || (next_state == DONE);
      case (state)
        IDLE, DONE, ERR: if (bus.start) index <= 16'h0000;
        LEN_HI:          if (accept) len_hi <= bus.byte_data;
        LEN_LO:          if (accept) len <= len_word;
        DATA_HI:         if (accept) data_hi <= bus.byte_data;
        DATA_LO: begin
          if (accept) begin
            addr_q  <= BASE_ADDR + index;
            wdata_q <= {data_hi, bus.byte_data};
          end
        end
        WRITE:           if (!last) index <= index + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear)
      checksum <= 8'h00;
    else if ((state == IDLE || state == DONE || state == ERR) && bus.start)
      checksum <= 8'h00;
    else if (accept)
      checksum <= checksum ^ bus.byte_data;
  end
`endif

  assign bus.byte_ready = ready;
  assign bus.im_we      = (state == WRITE);
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.cpu_nclear = cpu_nclear_q;
  assign bus.done       = (state == DONE);
  assign bus.error      = (state == ERR);

endmodule
